// File: rtl/mc_main_ctrl_if.sv
// Control bus between the multi-cycle MIPS main controller and its datapath.
// The controller takes the master side; the datapath takes the slave side.
interface mc_main_ctrl_if;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state;

    modport master (
        input  Op, Zero, mem_ready,
        output PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
               illegal_op, mem_err, state
    );

    modport slave (
        output Op, Zero, mem_ready,
        input  PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
               illegal_op, mem_err, state
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences fetch/decode/
// execute/memory/writeback, stalls on mem_ready and flags bad opcodes/timeouts.
module mc_main_ctrl #(
    parameter int FETCH_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_main_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam int              CW  = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TMO = CW'(FETCH_TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          err_q, err_d;
    logic          mem_wait;

    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                      && !bus.mem_ready;

    // Waiting never changes state, so any non-wait cycle is a state change and clears the count.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if ((FETCH_TIMEOUT > 0) && mem_wait) begin
            cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
            if (cnt_d == TMO) err_d = 1'b1;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        illegal_d     = illegal_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = bus.mem_ready;
                state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: reg_write = 1'b1;
            default:   state_d   = S_FETCH;
        endcase
    end

    // Reset is asynchronous, so every output is masked with rst_n to kill any
    // request the moment reset falls, even before the state register clears.
    assign bus.PCWrite     = pc_write      & rst_n;
    assign bus.PCWriteCond = pc_write_cond & rst_n;
    assign bus.PCEn        = (pc_write | (pc_write_cond & bus.Zero)) & rst_n;
    assign bus.IorD        = iord          & rst_n;
    assign bus.MemRead     = mem_read      & rst_n;
    assign bus.MemWrite    = mem_write     & rst_n;
    assign bus.IRWrite     = ir_write      & rst_n;
    assign bus.MemtoReg    = mem_to_reg    & rst_n;
    assign bus.RegDst      = reg_dst       & rst_n;
    assign bus.RegWrite    = reg_write     & rst_n;
    assign bus.ALUSrcA     = alu_src_a     & rst_n;
    assign bus.ALUSrcB     = alu_src_b     & {2{rst_n}};
    assign bus.ALUop       = alu_op        & {2{rst_n}};
    assign bus.PCSource    = pc_source     & {2{rst_n}};
    assign bus.illegal_op  = illegal_q;
    assign bus.mem_err     = err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// Randomized instruction-level bench for mc_main_ctrl; the reference model expands
// each instruction into its expected step list and checks every cycle.
module tb_mc_main_ctrl;
    localparam int TMO = 4;

    localparam int FETCH = 0, DECODE = 1, MEMADDR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       pcw, pcwc, pcen, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_illegal = 1'b0;
    logic exp_err     = 1'b0;

    mc_main_ctrl_if bus_if ();

    mc_main_ctrl #(.FETCH_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    // Control word each step must present, written straight from the state table.
    function automatic ctrl_t exp_ctrl(input int st, input logic mr, input logic z);
        ctrl_t c = '0;
        case (st)
            FETCH:   begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; c.pcen = mr; end
            DECODE:  c.asb = 2'b11;
            MEMADDR: begin c.asa = 1; c.asb = 2'b10; end
            MEMRD:   begin c.mrd = 1; c.iord = 1; end
            MEMWB:   begin c.rw = 1; c.m2r = 1; end
            MEMWR:   begin c.iord = 1; c.mwr = mr; end
            EXEC:    begin c.asa = 1; c.aop = 2'b10; end
            RWB:     begin c.rw = 1; c.rdst = 1; end
            BRANCH:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.pcen = z; end
            JUMP:    begin c.pcw = 1; c.pcen = 1; c.pcs = 2'b10; end
            ADDI_EX: begin c.asa = 1; c.asb = 2'b10; end
            ADDI_WB: c.rw = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c = {bus_if.PCWrite, bus_if.PCWriteCond, bus_if.PCEn, bus_if.IorD, bus_if.MemRead,
             bus_if.MemWrite, bus_if.IRWrite, bus_if.MemtoReg, bus_if.RegDst, bus_if.RegWrite,
             bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUop, bus_if.PCSource};
        return c;
    endfunction

    // One clock of an instruction step; k is how many wait cycles this step has already spent.
    task automatic do_cycle(input int st, input logic mr, input int k, input logic [5:0] op);
        logic z;
        bit   is_mem;
        @(negedge clk);
        z = 1'($urandom_range(0, 1));
        bus_if.Op = op;
        bus_if.mem_ready = mr;
        bus_if.Zero = z;
        #1;
        is_mem = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
        check_eq($sformatf("state op=%b k=%0d", op, k), 32'(bus_if.state), 32'(st));
        check_eq($sformatf("ctrl st=%0d mr=%0b z=%0b", st, mr, z), 32'(dut_ctrl()), 32'(exp_ctrl(st, mr, z)));
        check_eq($sformatf("illegal_op st=%0d", st), 32'(bus_if.illegal_op), 32'(exp_illegal));
        check_eq($sformatf("mem_err st=%0d k=%0d", st, k), 32'(bus_if.mem_err), 32'(exp_err));
        if (is_mem && !mr && (k + 1 >= TMO)) exp_err = 1'b1;
        if (st == DECODE && !is_legal(op)) exp_illegal = 1'b1;
    endtask

    task automatic mem_step(input int st, input int w, input logic [5:0] op);
        for (int k = 0; k <= w; k++) do_cycle(st, k == w, k, op);
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit abort);
        int t0 = $time;
        mem_step(FETCH, wf, op);
        do_cycle(DECODE, 1'($urandom_range(0, 1)), 0, op);
        case (op)
            OP_LW: begin
                do_cycle(MEMADDR, 1'($urandom_range(0, 1)), 0, op);
                mem_step(MEMRD, wm, op);
                if (abort) begin
                    @(negedge clk);
                    bus_if.mem_ready = 1'b1;
                    #1;
                    check_eq("abort pre state", 32'(bus_if.state), 32'(MEMWB));
                    check_eq("abort pre RegWrite", 32'(bus_if.RegWrite), 32'd1);
                    #1 rst_n = 1'b0;
                    #1;
                    check_eq("abort state", 32'(bus_if.state), 32'(FETCH));
                    check_eq("abort ctrl", 32'(dut_ctrl()), 32'd0);
                    check_eq("abort illegal_op", 32'(bus_if.illegal_op), 32'd0);
                    check_eq("abort mem_err", 32'(bus_if.mem_err), 32'd0);
                    exp_illegal = 1'b0;
                    exp_err     = 1'b0;
                    @(posedge clk);
                    #1 rst_n = 1'b1;
                end else begin
                    do_cycle(MEMWB, 1'($urandom_range(0, 1)), 0, op);
                end
            end
            OP_SW: begin
                do_cycle(MEMADDR, 1'($urandom_range(0, 1)), 0, op);
                mem_step(MEMWR, wm, op);
            end
            OP_R: begin
                do_cycle(EXEC, 1'($urandom_range(0, 1)), 0, op);
                do_cycle(RWB, 1'($urandom_range(0, 1)), 0, op);
            end
            OP_BEQ:  do_cycle(BRANCH, 1'($urandom_range(0, 1)), 0, op);
            OP_J:    do_cycle(JUMP, 1'($urandom_range(0, 1)), 0, op);
            OP_ADDI: begin
                do_cycle(ADDI_EX, 1'($urandom_range(0, 1)), 0, op);
                do_cycle(ADDI_WB, 1'($urandom_range(0, 1)), 0, op);
            end
            default: ;
        endcase
        $display("[TB] instr op=%b wf=%0d wm=%0d abort=%0b cycles=%0d", op, wf, wm, abort,
                 ($time - t0) / 10);
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 4) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
    endfunction

    initial begin
        logic [5:0] op;
        logic [5:0] ops [6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        rst_n = 1'b0;
        bus_if.Op = 6'd0;
        bus_if.Zero = 1'b0;
        bus_if.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset state", 32'(bus_if.state), 32'(FETCH));
        check_eq("reset ctrl", 32'(dut_ctrl()), 32'd0);
        check_eq("reset illegal_op", 32'(bus_if.illegal_op), 32'd0);
        check_eq("reset mem_err", 32'(bus_if.mem_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_LW, 0, 3, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(OP_SW, 1, 6, 1'b0);
        run_instr(OP_LW, 0, 0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                if (is_legal(op)) op = 6'b111111;
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, pick_wait(), pick_wait(), (op == OP_LW) && ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Main control FSM of the multi-cycle MIPS-subset CPU.
- Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and muxes, and produces the 2-bit ALUop consumed by the ALU control decoder (00 = addu, 01 = sub, 10 = use funct).
- Stalls on a memory ready handshake; flags unsupported opcodes.

Parameters:
- FETCH_TIMEOUT, 0, max cycles to wait for mem_ready in any memory state before raising mem_err; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  instruction opcode IR[31:26]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if Zero (beq)
- PCEn  out  1  PCWrite | (PCWriteCond & Zero)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUop  out  2  to ALU control decoder
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  sticky flag, set on unsupported opcode
- mem_err  out  1  sticky flag, set on mem_ready timeout
- state  out  4  current state, for debug

Behaviour:
- Only the state register and the two sticky flags are sequential. All other outputs are decoded combinationally from state (Moore), except that IRWrite, PCWrite and MemWrite in the memory states are also gated with mem_ready.
- rst_n = 0 (asynchronous): state = FETCH (0), illegal_op = 0, mem_err = 0, timeout counter = 0. Every enable and request output (PCWrite, PCWriteCond, PCEn, MemRead, MemWrite, IRWrite, RegWrite) is forced to 0 while rst_n is low. Mux selects read 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.

States, outputs and transitions (signals not listed are 0):
- FETCH (0): MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUop = 00, PCSource = 00. IRWrite and PCWrite = mem_ready. Go to DECODE when mem_ready = 1, otherwise stay.
- DECODE (1): ALUSrcA = 0, ALUSrcB = 11, ALUop = 00 (branch target). Next state by Op:
  - lw or sw → MEMADDR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EX
  - any other opcode → set illegal_op, go to FETCH
- MEMADDR (2): ALUSrcA = 1, ALUSrcB = 10, ALUop = 00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD (3): MemRead = 1, IorD = 1. Go to MEMWB when mem_ready = 1, otherwise stay.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0. Go to FETCH.
- MEMWR (5): IorD = 1; MemWrite is asserted only while mem_ready = 1. Go to FETCH when mem_ready = 1, otherwise stay.
- EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUop = 10. Go to RWB.
- RWB (7): RegWrite = 1, RegDst = 1, MemtoReg = 0. Go to FETCH.
- BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUop = 01, PCWriteCond = 1, PCSource = 01. Go to FETCH.
- JUMP (9): PCWrite = 1, PCSource = 10. Go to FETCH.
- ADDI_EX (10): ALUSrcA = 1, ALUSrcB = 10, ALUop = 00. Go to ADDI_WB.
- ADDI_WB (11): RegWrite = 1, RegDst = 0, MemtoReg = 0. Go to FETCH.
- Encodings 12–15 are unreachable; if entered, go to FETCH on the next edge with all enables 0.

Timing and flags:
- Latency with mem_ready tied high: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- Timeout (FETCH_TIMEOUT > 0): a counter increments in any memory-wait cycle (FETCH, MEMRD or MEMWR with mem_ready = 0) and clears on state change.
  - When the count reaches FETCH_TIMEOUT: set mem_err and keep waiting. No transition is forced.
- illegal_op and mem_err stay set until reset.
- Reset asserted mid-instruction aborts it immediately. No partial write may be issued after rst_n falls.

Test Plan:
- Reset mid-instruction: pulse rst_n low for 1 cycle while in MEMWB → state = 0 asynchronously, RegWrite = 0, all flags 0.
- R-type, Op = 000000, mem_ready = 1: state sequence 0, 1, 6, 7, 0. ALUop = 10 in state 6. RegWrite = 1 and RegDst = 1 only in state 7.
- lw with mem_ready held low for 3 cycles in MEMRD: state stays 3 for 4 cycles with MemRead = 1 and IorD = 1, then goes 4 → 0. Total 8 cycles.
- beq, Op = 000100: with Zero = 1 → PCEn = 1 in state 8, ALUop = 01. With Zero = 0 → PCEn = 0 throughout state 8.
- Illegal opcode, Op = 111111: state 0 → 1 → 0, illegal_op = 1 and stays 1; RegWrite and MemWrite never asserted.
- sw with FETCH_TIMEOUT = 4 and mem_ready low for 6 cycles in MEMWR: mem_err rises after the 4th wait cycle. MemWrite = 1 only in the completing cycle, then state = 0.
